// File: rtl/onn_uart_pkg.sv
// onn_uart_pkg: definitions shared by the ONN UART input and output stages.
// One gray<->phase mapping lives here so both directions stay exact inverses.
package onn_uart_pkg;

    // Default number of clk cycles per UART bit
    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    // Receiver states. PARITY is only entered when UART_IN_PARITY_EN is defined.
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Grayscale byte to phase: the inverse of gray = min(phi*32, 255)
    function automatic logic [3:0] g2p(input logic [7:0] gray);
        logic [3:0] phi;
        if (gray == 8'hFF) begin
            phi = 4'd8;
        end else begin
            phi = {1'b0, gray[7:5]};
        end
        return phi;
    endfunction

    // Phase to grayscale byte, saturating at 255 for phase 8 and above
    function automatic logic [7:0] p2g(input logic [3:0] phi);
        logic [7:0] gray;
        if (phi >= 4'd8) begin
            gray = 8'hFF;
        end else begin
            gray = {phi[2:0], 5'b00000};
        end
        return gray;
    endfunction

    // Even-parity bit for a data byte (makes the total count of ones even)
    function automatic logic parity_bit(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronises the UART line and receives one byte per frame.
// 8N1 by default; defining UART_IN_PARITY_EN adds an even-parity bit (8E1).
// Emits a one-cycle byte_valid with the byte, or a one-cycle err on a bad
// stop/parity bit, after which it waits for the line to return high.
module uart_rx_byte
    import onn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err,
    output logic       idle
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST  = TW'(CLKS_PER_BIT - 1);

    logic          meta_r;
    logic          rx_s;
    rx_state_t     state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    byte_r;
    logic          valid_r;
    logic          err_r;

    assign byte_valid = valid_r;
    assign rx_byte    = byte_r;
    assign err        = err_r;
    assign idle       = (state_r == RX_IDLE);

    // Two-flop synchroniser; resets to the idle-high level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            meta_r <= RxD;
            rx_s   <= meta_r;
        end
    end

    // Frame receiver: mid-bit sampling driven by the bit timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RX_IDLE;
            timer_r   <= TIMER_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            byte_r    <= 8'd0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    if (!rx_s) begin
                        timer_r <= TIMER_ZERO;
                        state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer_r == HALF_LAST) begin
                        if (rx_s) begin
                            // Line went high again before mid-start: a glitch, not a frame
                            state_r <= RX_IDLE;
                        end else begin
                            timer_r   <= TIMER_ZERO;
                            bit_idx_r <= 3'd0;
                            state_r   <= RX_DATA;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                RX_DATA: begin
                    if (timer_r == FULL_LAST) begin
                        shift_r[bit_idx_r] <= rx_s;
                        timer_r            <= TIMER_ZERO;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_IN_PARITY_EN
                            state_r <= RX_PARITY;
`else
                            state_r <= RX_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
`ifdef UART_IN_PARITY_EN
                RX_PARITY: begin
                    if (timer_r == FULL_LAST) begin
                        timer_r <= TIMER_ZERO;
                        if (parity_bit(shift_r) != rx_s) begin
                            err_r   <= 1'b1;
                            state_r <= RX_WAIT_HIGH;
                        end else begin
                            state_r <= RX_STOP;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
`endif
                RX_STOP: begin
                    if (timer_r == FULL_LAST) begin
                        timer_r <= TIMER_ZERO;
                        if (rx_s) begin
                            byte_r  <= shift_r;
                            valid_r <= 1'b1;
                            state_r <= RX_IDLE;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= RX_WAIT_HIGH;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low (break) line must not be mistaken for a new start bit
                    if (rx_s) begin
                        state_r <= RX_IDLE;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_in_pattern.sv
// uart_in_pattern: loads the ONN initial-phase pattern from a host over UART.
// Each received grayscale byte becomes a 4-bit phase written into the next
// pixel slot of phi_in; load_done pulses when slot N-1 is written. A partial
// pattern left idle for TIMEOUT_BITS bit-times restarts at pixel 0.
// Optional 8E1 framing: define UART_IN_PARITY_EN.
module uart_in_pattern
    import onn_uart_pkg::*;
#(
    parameter int N            = 210,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           RxD,
    output logic [0:4*N-1] phi_in,
    output logic           load_done,
    output logic           busy,
    output logic           frame_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
    localparam logic [IW-1:0] INDEX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] INDEX_ONE  = IW'(1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(N - 1);
    localparam logic [TW-1:0] TICK_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BITS_ONE   = BW'(1);
    localparam logic [BW-1:0] BITS_LAST  = BW'(TIMEOUT_BITS - 1);

    logic           byte_valid_s;
    logic [7:0]     rx_byte_s;
    logic           err_s;
    logic           rx_idle_s;
    logic           armed_s;
    logic           tick_last_s;
    logic           timeout_s;

    logic [0:4*N-1] phi_r;
    logic [IW-1:0]  index_r;
    logic [TW-1:0]  tick_r;
    logic [BW-1:0]  bits_r;
    logic           load_done_r;
    logic           busy_r;
    logic           frame_err_r;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .byte_valid(byte_valid_s),
        .rx_byte   (rx_byte_s),
        .err       (err_s),
        .idle      (rx_idle_s)
    );

    // Timeout runs only while a partial pattern waits for its next start bit;
    // any start edge takes the receiver out of idle and so restarts the count
    assign armed_s     = rx_idle_s && (index_r != INDEX_ZERO) && !byte_valid_s;
    assign tick_last_s = (tick_r == TICK_LAST);
    assign timeout_s   = armed_s && tick_last_s && (bits_r == BITS_LAST);

    assign phi_in    = phi_r;
    assign load_done = load_done_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

    // Idle bit-time counter used to abandon a stalled partial pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r <= TICK_ZERO;
            bits_r <= BITS_ZERO;
        end else if (!armed_s || timeout_s) begin
            tick_r <= TICK_ZERO;
            bits_r <= BITS_ZERO;
        end else if (tick_last_s) begin
            tick_r <= TICK_ZERO;
            bits_r <= bits_r + BITS_ONE;
        end else begin
            tick_r <= tick_r + TICK_ONE;
        end
    end

    // Write each received phase into its slot, advance the pixel index, flag a complete pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            phi_r       <= {(4*N){1'b0}};
            index_r     <= INDEX_ZERO;
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            if (byte_valid_s) begin
                for (int k = 0; k < N; k++) begin
                    if (index_r == IW'(k)) begin
                        phi_r[4*k +: 4] <= g2p(rx_byte_s);
                    end
                end
                if (index_r == INDEX_LAST) begin
                    index_r     <= INDEX_ZERO;
                    load_done_r <= 1'b1;
                end else begin
                    index_r <= index_r + INDEX_ONE;
                end
            end else if (timeout_s) begin
                // Contents are kept; only the write position restarts
                index_r <= INDEX_ZERO;
            end
        end
    end

    // Status: busy while a pattern or byte is in flight, sticky frame error
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            busy_r <= (index_r != INDEX_ZERO) || !rx_idle_s || byte_valid_s;
            if (err_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_in_pattern.sv
// tb_uart_in_pattern: directed scenarios plus random byte streams, checked
// every cycle against a pattern-level model (slot array, write index, sticky
// error) that is updated when each frame's stop sample is due.
module tb_uart_in_pattern;

    localparam int N        = 4;
    localparam int CLKS     = 16;
    localparam int TMO_BITS = 64;
    localparam int HALF     = CLKS / 2;
`ifdef UART_IN_PARITY_EN
    localparam int NBITS    = 11;
    // Cycles from driving the start bit until a parity error shows on frame_err
    localparam int PAR_LAT  = 3 + HALF + 9 * CLKS + 1;
`else
    localparam int NBITS    = 10;
`endif
    // Cycles from driving the start bit until the stop-bit outcome is visible:
    // 2-flop sync + idle decision (3), half a start bit, the remaining bits, one write cycle
    localparam int DONE_LAT = 3 + HALF + (NBITS - 1) * CLKS + 1;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           RxD   = 1'b1;
    logic [0:4*N-1] phi_in;
    logic           load_done;
    logic           busy;
    logic           frame_err;

    uart_in_pattern #(
        .N(N), .CLKS_PER_BIT(CLKS), .TIMEOUT_BITS(TMO_BITS)
    ) dut (
        .clk(clk), .reset(reset), .RxD(RxD),
        .phi_in(phi_in), .load_done(load_done), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;   // 0 = byte written, 1 = frame error
        int val;
    } ev_t;

    ev_t evq[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    int  exp_phi[N];
    int  exp_idx  = 0;
    bit  exp_ferr = 1'b0;
    int  last_act = 0;
    int  ld_count = 0;

    function automatic int gray_to_phase(input int g);
        return (g == 255) ? 8 : g / 32;
    endfunction

    function automatic logic [0:4*N-1] pack_exp();
        logic [0:4*N-1] v;
        for (int k = 0; k < N; k++) v[4*k +: 4] = 4'(exp_phi[k]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: update the model and compare at the falling edge, then step past the rising edge
    task automatic step();
        ev_t e;
        bit  ld_exp;
        @(negedge clk);
        ld_exp = 1'b0;
        if (!reset) begin
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                if (e.kind == 0) begin
                    exp_phi[exp_idx] = gray_to_phase(e.val);
                    if (exp_idx == N - 1) begin
                        exp_idx = 0;
                        ld_exp  = 1'b1;
                    end else begin
                        exp_idx++;
                    end
                end else begin
                    exp_ferr = 1'b1;
                end
            end
            check("phi_in", phi_in, pack_exp());
            check("load_done", load_done, ld_exp);
            check("frame_err", frame_err, exp_ferr);
            if (load_done === 1'b1) ld_count++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        RxD   = 1'b1;
        evq.delete();
        exp_idx  = 0;
        exp_ferr = 1'b0;
        for (int k = 0; k < N; k++) exp_phi[k] = 0;
        last_act = cyc;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) step();
        if (exp_idx != 0 && cyc - last_act > TMO_BITS * CLKS + 16) exp_idx = 0;
        if (n >= 8 && evq.size() == 0) check("busy", busy, (exp_idx != 0));
    endtask

    // Drive one frame; abort_bit >= 0 resets the design in the middle of that data bit
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic par_flip, input int abort_bit);
        logic [10:0] frame;
        int          start;
        bit          bad_par;
        ev_t         e;
        start = cyc;
        if (exp_idx != 0 && start + 3 - last_act > TMO_BITS * CLKS) exp_idx = 0;
        frame    = {11{1'b1}};
        frame[0] = 1'b0;
        for (int b = 0; b < 8; b++) frame[b+1] = data[b];
`ifdef UART_IN_PARITY_EN
        bad_par  = par_flip;
        frame[9] = (^data) ^ par_flip;
`else
        bad_par  = 1'b0;
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        frame[NBITS-1] = stop_val;
        if (abort_bit < 0) begin
`ifdef UART_IN_PARITY_EN
            if (bad_par) begin
                e.cyc = start + PAR_LAT; e.kind = 1; e.val = 0;
            end else
`endif
            if (!stop_val) begin
                e.cyc = start + DONE_LAT; e.kind = 1; e.val = 0;
            end else begin
                e.cyc = start + DONE_LAT; e.kind = 0; e.val = int'(data);
            end
            evq.push_back(e);
            last_act = e.cyc;
        end
        for (int b = 0; b < NBITS; b++) begin
            RxD = frame[b];
            for (int t = 0; t < CLKS; t++) begin
                if (abort_bit >= 0 && b == abort_bit + 1 && t == HALF) begin
                    do_reset(2);
                    return;
                end
                step();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       sv;
        for (int k = 0; k < N; k++) exp_phi[k] = 0;
        do_reset(4);

        // Reset state
        step();
        check("rst_phi", phi_in, 16'h0000);
        check("rst_load_done", load_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        idle(10);

        // Full pattern
        ld_count = 0;
        send_frame(8'h00, 1'b1, 1'b0, -1); idle(6);
        send_frame(8'h40, 1'b1, 1'b0, -1); idle(6);
        send_frame(8'hE0, 1'b1, 1'b0, -1); idle(6);
        check("full_ld_before_last", ld_count, 0);
        send_frame(8'hFF, 1'b1, 1'b0, -1); idle(10);
        check("full_phi", phi_in, 16'h0278);
        check("full_ld_count", ld_count, 1);
        check("full_busy", busy, 1'b0);

        // Glitch: five low cycles are shorter than half a bit
        RxD = 1'b0;
        repeat (5) step();
        RxD = 1'b1;
        last_act = cyc + 11;
        idle(30);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_phi", phi_in, 16'h0278);

        // Framing error followed by a held-low line, then a good byte
        send_frame(8'h20, 1'b0, 1'b0, -1);
        RxD = 1'b0;
        repeat (100) step();
        RxD = 1'b1;
        last_act = cyc;
        idle(20);
        send_frame(8'h20, 1'b1, 1'b0, -1); idle(20);
        check("ferr_sticky", frame_err, 1'b1);
        check("ferr_phi", phi_in, 16'h1278);

        // Timeout abandons a partial pattern
        ld_count = 0;
        send_frame(8'hE0, 1'b1, 1'b0, -1); idle(6);
        send_frame(8'hE0, 1'b1, 1'b0, -1); idle(10);
        check("tmo_busy_partial", busy, 1'b1);
        idle(1300);
        check("tmo_busy_after", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h20, 1'b1, 1'b0, -1); idle(6);
        end
        check("tmo_ld_early", ld_count, 0);
        send_frame(8'h20, 1'b1, 1'b0, -1); idle(10);
        check("tmo_phi", phi_in, 16'h1111);
        check("tmo_ld_count", ld_count, 1);

        // Reset in the middle of data bit 4
        send_frame(8'h5A, 1'b1, 1'b0, 4);
        step();
        check("mid_rst_phi", phi_in, 16'h0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_ld", load_done, 1'b0);
        idle(10);
        send_frame(8'h40, 1'b1, 1'b0, -1); idle(10);
        check("mid_rst_slot0", phi_in, 16'h2000);

`ifdef UART_IN_PARITY_EN
        // Parity: bad parity discards the byte, good parity is accepted
        do_reset(3);
        idle(10);
        send_frame(8'h03, 1'b1, 1'b1, -1); idle(20);
        check("par_err", frame_err, 1'b1);
        check("par_discard", phi_in, 16'h0000);
        send_frame(8'h03, 1'b1, 1'b0, -1); idle(10);
        send_frame(8'h63, 1'b1, 1'b0, -1); idle(10);
        check("par_accept", phi_in, 16'h0300);
`endif

        // Random stream with occasional bad stop bits and long idles
        do_reset(3);
        idle(10);
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) d = 8'hFF;
            sv = ($urandom_range(0, 9) != 0);
`ifdef UART_IN_PARITY_EN
            send_frame(d, sv, ($urandom_range(0, 9) == 0), -1);
`else
            send_frame(d, sv, 1'b0, -1);
`endif
            if ($urandom_range(0, 9) == 0) idle(1300);
            else idle(int'($urandom_range(4, 300)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
